// File: rtl/line_prefetch.sv
// line_prefetch: fetches one line of WORDS 32-bit words from an SDRAM master into a local buffer.
// Define LINE_PREFETCH_DOUBLE_BUF_EN to fill one bank while the display reads the other.
module line_prefetch #(
   parameter int WORDS  = 160,
   parameter int ADDR_W = 25
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              line_start,
   input  logic [ADDR_W-1:0] line_base,
   output logic              read_req,
   output logic              write_req,
   output logic [ADDR_W-1:0] address_out,
   input  logic              ready,
   input  logic [31:0]       data_in,
   input  logic [7:0]        rd_index,
   output logic [31:0]       rd_data,
   output logic              busy,
   output logic              line_done,
   output logic              line_overrun
);

`ifdef LINE_PREFETCH_DOUBLE_BUF_EN
   localparam int BANKS = 2;
`else
   localparam int BANKS = 1;
`endif
   localparam int         DEPTH       = BANKS * WORDS;
   localparam int         MEM_AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [7:0] LAST_INDEX  = 8'(WORDS - 1);
   localparam logic [8:0] WORDS_LIMIT = 9'(WORDS);

   typedef enum logic [1:0] {IDLE, REQ, CAPTURE, DONE} state_t;

   state_t            state, state_next;
   logic [ADDR_W-1:0] base_addr;
   logic [7:0]        word_index;
   logic              accept_start;
   logic              last_word;
   logic [MEM_AW-1:0] wr_addr;
   logic [MEM_AW-1:0] rd_addr;
   logic [31:0]       line_buf [DEPTH];

   assign accept_start = (state == IDLE) && line_start;
   assign last_word    = (word_index == LAST_INDEX);

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (line_start) state_next = REQ;
         REQ:     if (ready) state_next = CAPTURE;
         CAPTURE: state_next = last_word ? DONE : REQ;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // read_req decodes straight from the state so an async reset removes it at once.
   always_comb begin
      read_req     = (state == REQ);
      write_req    = 1'b0;
      busy         = (state != IDLE);
      line_done    = (state == DONE);
      line_overrun = line_start && (state != IDLE);
   end

   // address_out is loaded whenever the next request begins and simply holds otherwise.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         base_addr   <= '0;
         word_index  <= '0;
         address_out <= '0;
      end else if (accept_start) begin
         base_addr   <= line_base;
         word_index  <= '0;
         address_out <= line_base;
      end else if ((state == CAPTURE) && !last_word) begin
         word_index  <= word_index + 8'd1;
         address_out <= base_addr + ADDR_W'(word_index) + ADDR_W'(1);
      end
   end

`ifdef LINE_PREFETCH_DOUBLE_BUF_EN
   logic fill_bank;

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         fill_bank <= 1'b0;
      end else if (accept_start) begin
         fill_bank <= ~fill_bank;
      end
   end

   always_comb begin
      wr_addr = fill_bank ? MEM_AW'(WORDS) + MEM_AW'(word_index) : MEM_AW'(word_index);
      rd_addr = fill_bank ? MEM_AW'(rd_index) : MEM_AW'(WORDS) + MEM_AW'(rd_index);
   end
`else
   always_comb begin
      wr_addr = MEM_AW'(word_index);
      rd_addr = MEM_AW'(rd_index);
   end
`endif

   // Buffer is deliberately left out of reset so a glitching reset keeps the last line.
   always_ff @(posedge Clk) begin
      if (state == CAPTURE) begin
         line_buf[wr_addr] <= data_in;
      end
   end

   // A same-edge write and read of one word returns the old word through nonblocking update.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         rd_data <= '0;
      end else if ({1'b0, rd_index} < WORDS_LIMIT) begin
         rd_data <= line_buf[rd_addr];
      end
   end

endmodule

// File: tb/tb_line_prefetch.sv
// tb_line_prefetch: randomized bench for line_prefetch with a cycle-level SDRAM master and buffer model.
// Build with LINE_PREFETCH_DOUBLE_BUF_EN defined to exercise the double-buffer case as well.
module tb_line_prefetch;
   localparam int WORDS  = 4;
   localparam int ADDR_W = 25;

   logic              Clk = 1'b0;
   logic              Reset = 1'b1;
   logic              line_start = 1'b0;
   logic [ADDR_W-1:0] line_base = '0;
   logic              ready = 1'b0;
   logic [31:0]       data_in = '0;
   logic [7:0]        rd_index = '0;
   logic              read_req, write_req, busy, line_done, line_overrun;
   logic [ADDR_W-1:0] address_out;
   logic [31:0]       rd_data;

   int n_checks = 0;
   int n_pass   = 0;

   logic [31:0] model_buf [WORDS];
   bit          model_valid [WORDS];
   logic [31:0] prev_line [WORDS];
`ifdef LINE_PREFETCH_DOUBLE_BUF_EN
   bit rd_check_en = 1'b0;
`else
   bit rd_check_en = 1'b1;
`endif

   line_prefetch #(.WORDS(WORDS), .ADDR_W(ADDR_W)) dut (
      .Clk(Clk), .Reset(Reset), .line_start(line_start), .line_base(line_base),
      .read_req(read_req), .write_req(write_req), .address_out(address_out),
      .ready(ready), .data_in(data_in), .rd_index(rd_index), .rd_data(rd_data),
      .busy(busy), .line_done(line_done), .line_overrun(line_overrun)
   );

   always #5 Clk = ~Clk;

   // What the display side should see for a word: the live line, or the previous line when double buffered.
   function automatic logic [31:0] display_word(input int idx);
`ifdef LINE_PREFETCH_DOUBLE_BUF_EN
      return prev_line[idx];
`else
      return model_buf[idx];
`endif
   endfunction

   function automatic bit display_known(input int idx);
`ifdef LINE_PREFETCH_DOUBLE_BUF_EN
      return 1'b1;
`else
      return model_valid[idx];
`endif
   endfunction

   // Acts as the SDRAM master for one line: ready one cycle after a request (plus optional stall), data the cycle after.
   task automatic fetch_line(input logic [ADDR_W-1:0] base, input int stall_word, input int stall_len,
                             input int overrun_word, input int reset_word, input logic [3:0] tag);
      int cycles, word, phase, wait_left, exp_cycles, idx;
      bit rd_pending, finished, overrun_now, overrun_used, aborted;
      logic [31:0] rd_exp, word_data;
      logic [ADDR_W-1:0] exp_addr;
      exp_cycles = 3 * WORDS + ((stall_word >= 0 && stall_word < WORDS) ? stall_len : 0);
      line_base = base;
      line_start = 1'b1;
      @(posedge Clk); #1;
      line_start = 1'b0;
      line_base = ADDR_W'($urandom);
      cycles = 0; word = 0; phase = 0; wait_left = 0;
      rd_pending = 0; finished = 0; overrun_used = 0; aborted = 0; rd_exp = '0;
      while (!finished) begin
         overrun_now = 0;
         exp_addr = base + ADDR_W'(word);
         if (rd_pending) begin
            n_checks++;
            if (rd_data !== rd_exp) $display("[TB] FAIL rd_data word %0d: got %h expected %h", idx, rd_data, rd_exp);
            else n_pass++;
         end
         rd_pending = 0;
         idx = $urandom_range(0, WORDS - 1);
         rd_index = 8'(idx);
         if (rd_check_en && display_known(idx)) begin
            rd_exp = display_word(idx);
            rd_pending = 1;
         end
         ready = 1'b0;
         data_in = $urandom;
         n_checks++;
         if (write_req !== 1'b0) $display("[TB] FAIL write_req: got %b expected 0", write_req);
         else n_pass++;
         if (phase != 3) begin
            n_checks++;
            if (busy !== 1'b1 || line_done !== 1'b0)
               $display("[TB] FAIL busy/line_done mid-line: got %b/%b expected 1/0", busy, line_done);
            else n_pass++;
         end
         case (phase)
            0: begin
               n_checks++;
               if (read_req !== 1'b1 || address_out !== exp_addr)
                  $display("[TB] FAIL request word %0d: got req=%b addr=%h expected req=1 addr=%h", word, read_req, address_out, exp_addr);
               else n_pass++;
               if (read_req === 1'b1) begin
                  phase = 1;
                  wait_left = (word == stall_word) ? stall_len : 0;
               end
            end
            1: begin
               n_checks++;
               if (read_req !== 1'b1 || address_out !== exp_addr)
                  $display("[TB] FAIL request hold word %0d: got req=%b addr=%h expected req=1 addr=%h", word, read_req, address_out, exp_addr);
               else n_pass++;
               if (word == overrun_word && !overrun_used) begin
                  line_start = 1'b1;
                  line_base = ADDR_W'($urandom);
                  overrun_now = 1;
                  overrun_used = 1;
               end
               if (wait_left > 0) wait_left--;
               else begin
                  ready = 1'b1;
                  phase = 2;
               end
            end
            2: begin
               n_checks++;
               if (read_req !== 1'b0 || address_out !== exp_addr)
                  $display("[TB] FAIL capture word %0d: got req=%b addr=%h expected req=0 addr=%h", word, read_req, address_out, exp_addr);
               else n_pass++;
               word_data = {tag, 28'($urandom)};
               data_in = word_data;
               if (word == reset_word) begin
                  aborted = 1;
               end else begin
                  model_buf[word] = word_data;
                  model_valid[word] = 1'b1;
                  word++;
                  phase = (word == WORDS) ? 3 : 0;
               end
            end
            default: begin
               n_checks++;
               if (line_done !== 1'b1 || read_req !== 1'b0 || busy !== 1'b1 || cycles != exp_cycles)
                  $display("[TB] FAIL line_done: got done=%b req=%b busy=%b at cycle %0d expected 1/0/1 at cycle %0d",
                           line_done, read_req, busy, cycles, exp_cycles);
               else n_pass++;
               finished = 1;
            end
         endcase
         #1;
         n_checks++;
         if (line_overrun !== overrun_now) $display("[TB] FAIL line_overrun: got %b expected %b", line_overrun, overrun_now);
         else n_pass++;
         if (aborted) begin
            Reset = 1'b1;
            ready = 1'b0;
            #1;
            n_checks++;
            if (read_req !== 1'b0 || busy !== 1'b0 || line_done !== 1'b0 || rd_data !== 32'h0)
               $display("[TB] FAIL async reset: got req=%b busy=%b done=%b rd=%h expected 0/0/0/0", read_req, busy, line_done, rd_data);
            else n_pass++;
            repeat (2) begin
               @(posedge Clk); #1;
               n_checks++;
               if (line_done !== 1'b0 || busy !== 1'b0) $display("[TB] FAIL held reset: got done=%b busy=%b expected 0/0", line_done, busy);
               else n_pass++;
            end
            Reset = 1'b0;
            finished = 1;
         end else if (!finished) begin
            @(posedge Clk); #1;
            line_start = 1'b0;
            cycles++;
            if (cycles > 200) begin
               n_checks++;
               $display("[TB] FAIL fetch timeout: got no line_done after %0d cycles, expected %0d", cycles, exp_cycles);
               finished = 1;
               aborted = 1;
            end
         end
      end
      if (!aborted) begin
         @(posedge Clk); #1;
         if (rd_pending) begin
            n_checks++;
            if (rd_data !== rd_exp) $display("[TB] FAIL rd_data after done: got %h expected %h", rd_data, rd_exp);
            else n_pass++;
         end
         n_checks++;
         if (busy !== 1'b0 || line_done !== 1'b0 || read_req !== 1'b0 || address_out !== base + ADDR_W'(WORDS - 1))
            $display("[TB] FAIL idle after line: got busy=%b done=%b req=%b addr=%h expected 0/0/0 addr=%h",
                     busy, line_done, read_req, address_out, base + ADDR_W'(WORDS - 1));
         else n_pass++;
      end
   endtask

   task automatic test_reset;
      $display("[TB] test_reset");
      Reset = 1'b1;
      repeat (3) @(posedge Clk);
      #1;
      n_checks++;
      if (read_req !== 1'b0 || write_req !== 1'b0) $display("[TB] FAIL reset req: got %b/%b expected 0/0", read_req, write_req);
      else n_pass++;
      n_checks++;
      if (address_out !== '0) $display("[TB] FAIL reset address_out: got %h expected 0", address_out);
      else n_pass++;
      n_checks++;
      if (busy !== 1'b0 || line_done !== 1'b0 || line_overrun !== 1'b0)
         $display("[TB] FAIL reset status: got busy=%b done=%b overrun=%b expected 0/0/0", busy, line_done, line_overrun);
      else n_pass++;
      n_checks++;
      if (rd_data !== 32'h0) $display("[TB] FAIL reset rd_data: got %h expected 0", rd_data);
      else n_pass++;
      Reset = 1'b0;
      @(posedge Clk); #1;
      n_checks++;
      if (busy !== 1'b0 || read_req !== 1'b0) $display("[TB] FAIL idle after reset: got busy=%b req=%b expected 0/0", busy, read_req);
      else n_pass++;
   endtask

   task automatic test_basic;
      $display("[TB] test_basic");
      fetch_line(25'h0001000, -1, 0, -1, -1, 4'($urandom));
   endtask

   task automatic test_readback;
      int idx;
      $display("[TB] test_readback");
      for (int i = 0; i < 8; i++) begin
         idx = $urandom_range(0, WORDS - 1);
         rd_index = 8'(idx);
         @(posedge Clk); #1;
         if (model_valid[idx]) begin
            n_checks++;
            if (rd_data !== model_buf[idx]) $display("[TB] FAIL readback word %0d: got %h expected %h", idx, rd_data, model_buf[idx]);
            else n_pass++;
         end
      end
      rd_index = 8'd200;
      @(posedge Clk); #1;
      n_checks++;
      if (busy !== 1'b0 || read_req !== 1'b0) $display("[TB] FAIL out-of-range read: got busy=%b req=%b expected 0/0", busy, read_req);
      else n_pass++;
   endtask

   task automatic test_stall;
      $display("[TB] test_stall");
      fetch_line(ADDR_W'($urandom), 2, 5, -1, -1, 4'($urandom));
   endtask

   task automatic test_wrap;
      $display("[TB] test_wrap");
      fetch_line(25'h1FFFFFE, -1, 0, -1, -1, 4'($urandom));
   endtask

   task automatic test_overrun;
      $display("[TB] test_overrun");
      fetch_line(ADDR_W'($urandom), -1, 0, 1, -1, 4'($urandom));
   endtask

   task automatic test_reset_midfetch;
      $display("[TB] test_reset_midfetch");
      fetch_line(ADDR_W'($urandom), -1, 0, -1, 2, 4'($urandom));
      fetch_line(ADDR_W'($urandom), -1, 0, -1, -1, 4'($urandom));
   endtask

   task automatic test_back_to_back;
      $display("[TB] test_back_to_back");
      for (int i = 0; i < 4; i++) begin
         fetch_line(ADDR_W'($urandom), $urandom_range(0, WORDS - 1), $urandom_range(0, 4), -1, -1, 4'($urandom));
      end
   endtask

`ifdef LINE_PREFETCH_DOUBLE_BUF_EN
   task automatic test_double_buffer;
      $display("[TB] test_double_buffer");
      rd_check_en = 1'b0;
      fetch_line(ADDR_W'($urandom), -1, 0, -1, -1, 4'hA);
      for (int i = 0; i < WORDS; i++) prev_line[i] = model_buf[i];
      rd_check_en = 1'b1;
      fetch_line(ADDR_W'($urandom), -1, 0, -1, -1, 4'hB);
      rd_check_en = 1'b0;
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
`ifndef LINE_PREFETCH_DOUBLE_BUF_EN
      test_readback();
`endif
      test_stall();
      test_wrap();
      test_overrun();
      test_reset_midfetch();
`ifndef LINE_PREFETCH_DOUBLE_BUF_EN
      test_readback();
`endif
      test_back_to_back();
`ifdef LINE_PREFETCH_DOUBLE_BUF_EN
      test_double_buffer();
`endif
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
